// File: rtl/sdram_responder.sv
// sdram_responder: SDR SDRAM device emulator backed by an internal word array.
// Decodes controller commands, tracks open rows, serves bursts, flags protocol violations.
module sdram_responder #(
  parameter int MEM_ADDR_BITS = 12,
  parameter int COL_BITS      = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_cke,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_wre_n,
  input  logic [12:0] sdram_a,
  input  logic [1:0]  sdram_ba,
  input  logic [1:0]  sdram_dqm,
  input  logic [15:0] sdram_dq_in,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic        mode_loaded,
  output logic        protocol_error
);
  typedef enum logic [2:0] {
    C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
    C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111
  } cmd_e;
  logic [3:0] act_q, act_d;
  logic [12:0] row_q [4];
  logic [1:0] bl_q;
  logic cl3_q, mode_q, err_q;
  logic bst_q, bwr_q, bap_q;
  logic [1:0] bbank_q;
  logic [12:0] brow_q;
  logic [COL_BITS-1:0] bcol_q;
  logic [2:0] bidx_q;
  logic s1_q, s2_q, oe_q;
  logic [15:0] rdata_q, s2d_q, dq_q;
  logic [15:0] mem [0:(1<<MEM_ADDR_BITS)-1];
  cmd_e cmd;
  logic rw, start, stop, go, last, wcancel, err_set, s_wr, s_ap;
  logic [1:0] s_bank;
  logic [12:0] s_row;
  logic [COL_BITS-1:0] s_col, cmask, wcol;
  logic [2:0] s_idx, lenm;
  logic [MEM_ADDR_BITS-1:0] maddr;
  assign cmd     = (sdram_cke && !sdram_cs_n) ? cmd_e'({sdram_ras_n, sdram_cas_n, sdram_wre_n}) : C_NOP;
  assign rw      = cmd == C_RD || cmd == C_WR;
  assign start   = rw && act_q[sdram_ba];
  assign stop    = start || cmd == C_BST || (cmd == C_PRE && (sdram_a[10] || sdram_ba == bbank_q));
  assign go      = start || (sdram_cke && bst_q && !stop);
  assign wcancel = start && cmd == C_WR;
  assign s_wr    = start ? cmd == C_WR : bwr_q;
  assign s_ap    = start ? sdram_a[10] : bap_q;
  assign s_bank  = start ? sdram_ba : bbank_q;
  assign s_row   = start ? row_q[sdram_ba] : brow_q;
  assign s_col   = start ? sdram_a[COL_BITS-1:0] : bcol_q;
  assign s_idx   = start ? 3'd0 : bidx_q;
  assign lenm    = 3'((4'd1 << bl_q) - 4'd1);
  assign last    = s_idx == lenm;
  // Burst wraps inside its BL-aligned column block.
  assign cmask   = COL_BITS'(lenm);
  assign wcol    = (s_col & ~cmask) | ((s_col + COL_BITS'(s_idx)) & cmask);
  assign maddr   = MEM_ADDR_BITS'({s_bank, s_row, wcol});
  assign err_set = (rw && !act_q[sdram_ba]) || (cmd == C_ACT && act_q[sdram_ba]) ||
                   (cmd == C_REF && |act_q) || ((rw || cmd == C_ACT) && !mode_q) ||
                   (cmd == C_LMR && (sdram_a[2] || sdram_a[6:5] != 2'b01));
  always_comb begin
    act_d = act_q;
    if (go && last && s_ap) act_d[s_bank] = 1'b0;
    if (cmd == C_PRE) begin
      if (sdram_a[10]) act_d = '0;
      else act_d[sdram_ba] = 1'b0;
    end
    if (cmd == C_ACT) act_d[sdram_ba] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= '0; bl_q <= '0; cl3_q <= 1'b0; mode_q <= 1'b0; err_q <= 1'b0;
      bst_q <= 1'b0; bwr_q <= 1'b0; bap_q <= 1'b0; bbank_q <= '0; brow_q <= '0;
      bcol_q <= '0; bidx_q <= '0; s1_q <= 1'b0; s2_q <= 1'b0; oe_q <= 1'b0;
      s2d_q <= '0; dq_q <= '0;
    end else if (sdram_cke) begin
      act_q <= act_d;
      err_q <= err_q | err_set;
      if (cmd == C_LMR) begin
        mode_q <= 1'b1;
        bl_q   <= sdram_a[2] ? 2'd0 : sdram_a[1:0];
        cl3_q  <= sdram_a[6:4] == 3'b011;
      end
      if (start) begin
        bwr_q <= s_wr; bap_q <= s_ap; bbank_q <= s_bank; brow_q <= s_row; bcol_q <= s_col;
      end
      bst_q  <= go && !last;
      bidx_q <= s_idx + 3'd1;
      // A write cancels every read word still in flight.
      if (wcancel) begin
        s1_q <= 1'b0; s2_q <= 1'b0; oe_q <= 1'b0; s2d_q <= '0; dq_q <= '0;
      end else begin
        s1_q  <= go && !s_wr;
        s2_q  <= s1_q;
        s2d_q <= s1_q ? rdata_q : '0;
        oe_q  <= cl3_q ? s2_q : s1_q;
        dq_q  <= cl3_q ? s2d_q : (s1_q ? rdata_q : '0);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (cmd == C_ACT) row_q[sdram_ba] <= sdram_a;
  end
  always_ff @(posedge clk) begin
    if (sdram_cke) begin
      if (go && s_wr) begin
        if (!sdram_dqm[1]) mem[maddr][15:8] <= sdram_dq_in[15:8];
        if (!sdram_dqm[0]) mem[maddr][7:0] <= sdram_dq_in[7:0];
      end
      rdata_q <= mem[maddr];
    end
  end
  assign sdram_dq_out   = dq_q;
  assign sdram_dq_oe    = oe_q;
  assign mode_loaded    = mode_q;
  assign protocol_error = err_q;
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed vectors for sdram_responder, inputs driven on the falling edge.
module tb_sdram_responder;
  localparam logic [2:0] LMR = 3'b000, REF = 3'b001, ACT = 3'b011, WR = 3'b100,
                         RD = 3'b101, BST = 3'b110, NOP = 3'b111;
  logic clk = 1'b0, rst, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_wre_n;
  logic [12:0] sdram_a;
  logic [1:0] sdram_ba, sdram_dqm;
  logic [15:0] sdram_dq_in, sdram_dq_out;
  logic sdram_dq_oe, mode_loaded, protocol_error;
  int n_chk = 0, n_pass = 0;
  sdram_responder dut (
    .clk(clk), .rst(rst), .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n),
    .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_wre_n(sdram_wre_n),
    .sdram_a(sdram_a), .sdram_ba(sdram_ba), .sdram_dqm(sdram_dqm),
    .sdram_dq_in(sdram_dq_in), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
    .mode_loaded(mode_loaded), .protocol_error(protocol_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic cyc(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                     input logic [15:0] d, input logic [1:0] m);
    @(negedge clk);
    {sdram_ras_n, sdram_cas_n, sdram_wre_n} = c;
    sdram_ba = b; sdram_a = a; sdram_dq_in = d; sdram_dqm = m;
  endtask
  task automatic wr(input logic [1:0] b, input logic [12:0] a, input logic [63:0] ws,
                    input logic [7:0] ms);
    cyc(WR, b, a, ws[63:48], ms[7:6]);
    for (int i = 1; i < 4; i++) cyc(NOP, b, a, ws[63-16*i -: 16], ms[7-2*i -: 2]);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b11);
  endtask
  task automatic rd(input string tag, input logic [1:0] b, input logic [12:0] a,
                    input int cl, input int n, input logic [63:0] ws);
    cyc(RD, b, a, 16'd0, 2'b00);
    for (int i = 1; i < cl; i++) begin
      cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
      chk({tag, "_lat_oe"}, 16'(sdram_dq_oe), 16'd0);
    end
    for (int i = 0; i < n; i++) begin
      cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
      chk({tag, "_oe"}, 16'(sdram_dq_oe), 16'd1);
      chk({tag, "_dq"}, sdram_dq_out, ws[63-16*i -: 16]);
    end
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk({tag, "_end_oe"}, 16'(sdram_dq_oe), 16'd0);
  endtask
  task automatic pulse_rst;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1; sdram_cke = 1'b1; sdram_cs_n = 1'b0;
    {sdram_ras_n, sdram_cas_n, sdram_wre_n} = NOP;
    sdram_a = '0; sdram_ba = '0; sdram_dqm = '0; sdram_dq_in = '0;
    #3;
    chk("rst_oe", 16'(sdram_dq_oe), 16'd0);
    chk("rst_dq", sdram_dq_out, 16'd0);
    chk("rst_mode", 16'(mode_loaded), 16'd0);
    chk("rst_err", 16'(protocol_error), 16'd0);
    @(negedge clk); rst = 1'b0;
    cyc(LMR, 2'd0, 13'h022, 16'd0, 2'b00);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("mode_loaded", 16'(mode_loaded), 16'd1);
    cyc(ACT, 2'd0, 13'd5, 16'd0, 2'b00);
    wr(2'd0, 13'h000, 64'h1111_2222_3333_4444, 8'h00);
    rd("rd_bl4", 2'd0, 13'h000, 2, 4, 64'h1111_2222_3333_4444);
    chk("no_err", 16'(protocol_error), 16'd0);
    rd("rd_wrap", 2'd0, 13'h002, 2, 4, 64'h3333_4444_1111_2222);
    wr(2'd0, 13'h000, 64'hABCD_0000_0000_0000, 8'b10_11_11_11);
    cyc(LMR, 2'd0, 13'h030, 16'd0, 2'b00);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    rd("cl3_mask", 2'd0, 13'h000, 3, 1, 64'h11CD_0000_0000_0000);
    rd("cl3_col1", 2'd0, 13'h001, 3, 1, 64'h2222_0000_0000_0000);
    cyc(LMR, 2'd0, 13'h022, 16'd0, 2'b00);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    cyc(RD, 2'd0, 13'h000, 16'd0, 2'b00);
    cyc(BST, 2'd0, 13'd0, 16'd0, 2'b00);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("bst_w0_oe", 16'(sdram_dq_oe), 16'd1);
    chk("bst_w0_dq", sdram_dq_out, 16'h11CD);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("bst_stop_oe", 16'(sdram_dq_oe), 16'd0);
    cyc(RD, 2'd0, 13'h000, 16'd0, 2'b00);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("cke_w0", sdram_dq_out, 16'h11CD);
    sdram_cke = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
      chk("cke_hold_oe", 16'(sdram_dq_oe), 16'd1);
      chk("cke_hold_dq", sdram_dq_out, 16'h11CD);
    end
    sdram_cke = 1'b1;
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("cke_w1", sdram_dq_out, 16'h2222);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("cke_w2", sdram_dq_out, 16'h3333);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("cke_w3", sdram_dq_out, 16'h4444);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("cke_end_oe", 16'(sdram_dq_oe), 16'd0);
    wr(2'd0, 13'h400, 64'h5555_6666_7777_8888, 8'h00);
    chk("ap_pre_err", 16'(protocol_error), 16'd0);
    cyc(RD, 2'd0, 13'h000, 16'd0, 2'b00);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("ap_idle_err", 16'(protocol_error), 16'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
      chk("ap_idle_oe", 16'(sdram_dq_oe), 16'd0);
    end
    cyc(ACT, 2'd0, 13'd5, 16'd0, 2'b00);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    rd("ap_reopen", 2'd0, 13'h000, 2, 4, 64'h5555_6666_7777_8888);
    cyc(RD, 2'd0, 13'h000, 16'd0, 2'b00);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("mid_rst_before", 16'(sdram_dq_oe), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_oe", 16'(sdram_dq_oe), 16'd0);
    chk("mid_rst_dq", sdram_dq_out, 16'd0);
    chk("mid_rst_mode", 16'(mode_loaded), 16'd0);
    chk("mid_rst_err", 16'(protocol_error), 16'd0);
    @(negedge clk); rst = 1'b0;
    cyc(LMR, 2'd0, 13'h022, 16'd0, 2'b00);
    cyc(RD, 2'd1, 13'h000, 16'd0, 2'b00);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("idle_rd_err", 16'(protocol_error), 16'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
      chk("idle_rd_oe", 16'(sdram_dq_oe), 16'd0);
    end
    chk("idle_rd_sticky", 16'(protocol_error), 16'd1);
    pulse_rst();
    chk("clr_err", 16'(protocol_error), 16'd0);
    cyc(LMR, 2'd0, 13'h022, 16'd0, 2'b00);
    cyc(ACT, 2'd0, 13'd5, 16'd0, 2'b00);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("ref_pre_err", 16'(protocol_error), 16'd0);
    cyc(REF, 2'd0, 13'd0, 16'd0, 2'b00);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("ref_err", 16'(protocol_error), 16'd1);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("ref_err_sticky", 16'(protocol_error), 16'd1);
    pulse_rst();
    cyc(LMR, 2'd0, 13'h004, 16'd0, 2'b00);
    cyc(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("bad_mode_err", 16'(protocol_error), 16'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
